// File: rtl/mul_share_pkg.sv
// Shared types and widths for the shared-multiplier arbiter slice.
package mul_share_pkg;

  localparam int unsigned OPERAND_W = 16;
  localparam int unsigned PRODUCT_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mul_rr_picker.sv
// Combinational round-robin picker: first set req_valid bit at or above rr_ptr, wrapping.
module mul_rr_picker #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    gidx,
  output logic               any_valid
);

  always_comb begin
    int unsigned idx;
    logic [ID_W-1:0] sel;
    grant     = '0;
    gidx      = '0;
    any_valid = 1'b0;
    idx       = 0;
    sel       = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sel = ID_W'(idx);
      if (!any_valid && req_valid[sel]) begin
        any_valid  = 1'b1;
        gidx       = sel;
        grant[sel] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one external 16x16 multiplier among NUM_REQ requesters.
// Optional op_count statistics port enabled by MUL_SHARE_ARBITER_STATS_EN.
module mul_share_arbiter
  import mul_share_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [OPERAND_W*NUM_REQ-1:0]   req_a,
  input  logic [OPERAND_W*NUM_REQ-1:0]   req_b,
  output logic [OPERAND_W-1:0]           mul_a,
  output logic [OPERAND_W-1:0]           mul_b,
  input  logic [PRODUCT_W-1:0]           mul_result,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [PRODUCT_W-1:0]           rsp_data,
  output logic [ID_W-1:0]                rsp_id
`ifdef MUL_SHARE_ARBITER_STATS_EN
  ,
  output logic [15:0]                    op_count
`endif
);

  state_t               state;
  logic [ID_W-1:0]      rr_ptr;
  logic [ID_W-1:0]      id_q;
  logic [OPERAND_W-1:0] op_a_q;
  logic [OPERAND_W-1:0] op_b_q;

  logic [NUM_REQ-1:0]   grant;
  logic [ID_W-1:0]      gidx;
  logic                 any_valid;

  logic [OPERAND_W-1:0] a_arr [NUM_REQ];
  logic [OPERAND_W-1:0] b_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[i*OPERAND_W +: OPERAND_W];
    assign b_arr[i] = req_b[i*OPERAND_W +: OPERAND_W];
  end

  mul_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .gidx      (gidx),
    .any_valid (any_valid)
  );

  // Grant is combinational so a requester sees acceptance in the same cycle.
  always_comb begin
    req_ready = '0;
    if (state == ST_IDLE) req_ready = grant;
  end

  assign mul_a = op_a_q;
  assign mul_b = op_b_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      id_q      <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rsp_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_valid) begin
            op_a_q <= a_arr[gidx];
            op_b_q <= b_arr[gidx];
            id_q   <= gidx;
            rr_ptr <= (gidx == ID_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
            state  <= ST_CALC;
          end
        end
        ST_CALC: begin
          rsp_data  <= mul_result;
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef MUL_SHARE_ARBITER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) op_count <= '0;
    else if (rsp_valid && rsp_ready) op_count <= op_count + 1'b1;
  end
`endif

endmodule
